// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt front-end: FSM state encoding and default sizing.
package irq_controller_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_REQ     = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_e;

  localparam int DEF_N_SRC       = 4;
  localparam int DEF_ID_W        = 2;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source synchroniser chain plus history flop; o_edge pulses one cycle on a synchronised 0->1.
// Latency: the edge is visible SYNC_STAGES-1 cycles after the first sampling clock.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_irq,
  output logic o_edge
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/irq_controller.sv
// Interrupt front-end: synchronised edge capture, pending/mask registers, fixed-priority request FSM.
// Request rises SYNC_STAGES+1 clocks after a line is first sampled high; held until int_ack.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int                N_SRC       = DEF_N_SRC,
  parameter int                SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic [N_SRC-1:0]  MASK_RST    = '0,
  parameter int                ID_W        = DEF_ID_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             int_ack,
  input  logic             int_rti,
  output logic             int_sig,
  output logic [ID_W-1:0]  int_id,
  output logic             busy,
  output logic [N_SRC-1:0] pending_q,
  output logic [N_SRC-1:0] mask_q
);

  logic [N_SRC-1:0] w_edge;
  logic [N_SRC-1:0] w_eligible;
  logic [N_SRC-1:0] w_clr;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_mask;
  logic [ID_W-1:0]  r_int_id;
  logic [ID_W-1:0]  w_int_id_nxt;
  irq_state_e       r_state;
  irq_state_e       w_state_nxt;

  // Lowest set bit wins; scanning downward lets the last hit be the highest priority.
  function automatic logic [ID_W-1:0] f_lowest(input logic [N_SRC-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .clk   (clk),
      .rst   (rst),
      .i_irq (irq_in[g]),
      .o_edge(w_edge[g])
    );
  end

  assign w_eligible = r_pending & ~r_mask;
  assign w_clr      = (r_state == IRQ_REQ && int_ack) ? (N_SRC'(1) << r_int_id) : '0;

  // New edge is OR-ed in after the clear so a same-cycle re-trigger survives the ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_mask    <= MASK_RST;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_edge;
      if (mask_we) r_mask <= mask_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IRQ_IDLE;
      r_int_id <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_int_id <= w_int_id_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_int_id_nxt = r_int_id;
    unique case (r_state)
      IRQ_IDLE: begin
        if (|w_eligible) begin
          w_state_nxt  = IRQ_REQ;
          w_int_id_nxt = f_lowest(w_eligible);
        end
      end
      IRQ_REQ: begin
        if (int_ack) w_state_nxt = IRQ_SERVICE;
      end
      IRQ_SERVICE: begin
        if (int_rti) w_state_nxt = IRQ_IDLE;
      end
      default: w_state_nxt = IRQ_IDLE;
    endcase
  end

  assign int_sig   = (r_state == IRQ_REQ);
  assign busy      = (r_state == IRQ_SERVICE);
  assign int_id    = r_int_id;
  assign pending_q = r_pending;
  assign mask_q    = r_mask;

endmodule

// File: tb/tb_irq_controller.sv
// Table-driven cycle bench for irq_controller; each step's expected outputs go through a scoreboard queue.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       int_ack;
  logic       int_rti;
  logic       int_sig;
  logic [1:0] int_id;
  logic       busy;
  logic [3:0] pending_q;
  logic [3:0] mask_q;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic [3:0] irq;
    logic       mwe;
    logic [3:0] mwd;
    logic       ack;
    logic       rti;
    logic       sig;
    logic [1:0] id;
    logic       busy;
    logic [3:0] pend;
    logic [3:0] mask;
  } vec_t;

  typedef struct {
    logic       sig;
    logic [1:0] id;
    logic       busy;
    logic [3:0] pend;
    logic [3:0] mask;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];

  irq_controller #(
    .N_SRC      (4),
    .SYNC_STAGES(2),
    .MASK_RST   (4'h0),
    .ID_W       (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .int_ack   (int_ack),
    .int_rti   (int_rti),
    .int_sig   (int_sig),
    .int_id    (int_id),
    .busy      (busy),
    .pending_q (pending_q),
    .mask_q    (mask_q)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [3:0] irq, input logic mwe, input logic [3:0] mwd,
                     input logic ack, input logic rti, input logic sig, input logic [1:0] id,
                     input logic bsy, input logic [3:0] pend, input logic [3:0] msk);
    tbl.push_back('{r, irq, mwe, mwd, ack, rti, sig, id, bsy, pend, msk});
  endtask

  // Drive one cycle of inputs, expect the outputs seen just after the next rising edge.
  task automatic step(input string tag, input vec_t v);
    exp_t e;
    rst        = v.rst;
    irq_in     = v.irq;
    mask_we    = v.mwe;
    mask_wdata = v.mwd;
    int_ack    = v.ack;
    int_rti    = v.rti;
    sb_q.push_back('{v.sig, v.id, v.busy, v.pend, v.mask});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    if (int_sig !== e.sig || int_id !== e.id || busy !== e.busy ||
        pending_q !== e.pend || mask_q !== e.mask) begin
      errors++;
      $display("FAIL %s: got sig=%b id=%0d busy=%b pend=%b mask=%b, want sig=%b id=%0d busy=%b pend=%b mask=%b",
               tag, int_sig, int_id, busy, pending_q, mask_q, e.sig, e.id, e.busy, e.pend, e.mask);
    end
  endtask

  task automatic hs(input string tag, input logic r, input logic [3:0] irq, input logic mwe,
                    input logic [3:0] mwd, input logic ack, input logic rti, input logic sig,
                    input logic [1:0] id, input logic bsy, input logic [3:0] pend, input logic [3:0] msk);
    vec_t v;
    v = '{r, irq, mwe, mwd, ack, rti, sig, id, bsy, pend, msk};
    step(tag, v);
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; int_ack = 1'b0; int_rti = 1'b0;

    //   rst irq     mwe mwd     ack rti  sig id busy pend    mask
    // reset held with two lines high, then first request
    add(1, 4'b0011, 0, 4'b0000, 0, 0,   0, 0, 0, 4'b0000, 4'b0000);
    add(1, 4'b0011, 0, 4'b0000, 0, 0,   0, 0, 0, 4'b0000, 4'b0000);
    add(1, 4'b0011, 0, 4'b0000, 0, 0,   0, 0, 0, 4'b0000, 4'b0000);
    add(0, 4'b0011, 0, 4'b0000, 0, 0,   0, 0, 0, 4'b0000, 4'b0000);
    add(0, 4'b0011, 0, 4'b0000, 0, 0,   0, 0, 0, 4'b0000, 4'b0000);
    add(0, 4'b0011, 0, 4'b0000, 0, 0,   0, 0, 0, 4'b0011, 4'b0000);
    add(0, 4'b0011, 0, 4'b0000, 0, 0,   1, 0, 0, 4'b0011, 4'b0000);
    // ack source 0, service, rti, then source 1 follows
    add(0, 4'b0011, 0, 4'b0000, 1, 0,   0, 0, 1, 4'b0010, 4'b0000);
    add(0, 4'b0011, 0, 4'b0000, 0, 0,   0, 0, 1, 4'b0010, 4'b0000);
    add(0, 4'b0011, 0, 4'b0000, 0, 1,   0, 0, 0, 4'b0010, 4'b0000);
    add(0, 4'b0011, 0, 4'b0000, 0, 0,   1, 1, 0, 4'b0010, 4'b0000);
    add(0, 4'b0011, 0, 4'b0000, 1, 0,   0, 1, 1, 4'b0000, 4'b0000);
    add(0, 4'b0011, 0, 4'b0000, 0, 1,   0, 1, 0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   0, 1, 0, 4'b0000, 4'b0000);
    // masked source 2 stays latched, unmask releases it
    add(0, 4'b0000, 1, 4'b0100, 0, 0,   0, 1, 0, 4'b0000, 4'b0100);
    add(0, 4'b0100, 0, 4'b0000, 0, 0,   0, 1, 0, 4'b0000, 4'b0100);
    add(0, 4'b0100, 0, 4'b0000, 0, 0,   0, 1, 0, 4'b0000, 4'b0100);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   0, 1, 0, 4'b0100, 4'b0100);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   0, 1, 0, 4'b0100, 4'b0100);
    add(0, 4'b0000, 1, 4'b0000, 0, 0,   0, 1, 0, 4'b0100, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   1, 2, 0, 4'b0100, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 1, 0,   0, 2, 1, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 1,   0, 2, 0, 4'b0000, 4'b0000);
    // source 3 into service, then two pulses while busy
    add(0, 4'b1000, 0, 4'b0000, 0, 0,   0, 2, 0, 4'b0000, 4'b0000);
    add(0, 4'b1000, 0, 4'b0000, 0, 0,   0, 2, 0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   0, 2, 0, 4'b1000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   1, 3, 0, 4'b1000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 1, 0,   0, 3, 1, 4'b0000, 4'b0000);
    add(0, 4'b1000, 0, 4'b0000, 0, 0,   0, 3, 1, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   0, 3, 1, 4'b0000, 4'b0000);
    add(0, 4'b1000, 0, 4'b0000, 0, 0,   0, 3, 1, 4'b1000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   0, 3, 1, 4'b1000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   0, 3, 1, 4'b1000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   0, 3, 1, 4'b1000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 1,   0, 3, 0, 4'b1000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   1, 3, 0, 4'b1000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 1, 0,   0, 3, 1, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 1,   0, 3, 0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   0, 3, 0, 4'b0000, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 0, 0,   0, 3, 0, 4'b0000, 4'b0000);

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i]);
    end

    // Re-trigger of source 1 lands on the ack cycle; rti raised alongside ack must be ignored.
    hs("t5_a",    0, 4'b0010, 0, 4'b0000, 0, 0,   0, 3, 0, 4'b0000, 4'b0000);
    hs("t5_b",    0, 4'b0010, 0, 4'b0000, 0, 0,   0, 3, 0, 4'b0000, 4'b0000);
    hs("t5_pend", 0, 4'b0000, 0, 4'b0000, 0, 0,   0, 3, 0, 4'b0010, 4'b0000);
    hs("t5_req",  0, 4'b0000, 0, 4'b0000, 0, 0,   1, 1, 0, 4'b0010, 4'b0000);
    hs("t5_e",    0, 4'b0010, 0, 4'b0000, 0, 0,   1, 1, 0, 4'b0010, 4'b0000);
    hs("t5_f",    0, 4'b0000, 0, 4'b0000, 0, 0,   1, 1, 0, 4'b0010, 4'b0000);
    hs("t5_ack",  0, 4'b0000, 0, 4'b0000, 1, 1,   0, 1, 1, 4'b0010, 4'b0000);
    hs("t5_rti",  0, 4'b0000, 0, 4'b0000, 0, 1,   0, 1, 0, 4'b0010, 4'b0000);
    hs("t5_rreq", 0, 4'b0000, 0, 4'b0000, 0, 0,   1, 1, 0, 4'b0010, 4'b0000);
    hs("t5_ack2", 0, 4'b0000, 0, 4'b0000, 1, 0,   0, 1, 1, 4'b0000, 4'b0000);
    hs("t5_idle", 0, 4'b0000, 0, 4'b0000, 0, 1,   0, 1, 0, 4'b0000, 4'b0000);

    // Reset while requesting: everything clears, a stray ack afterwards does nothing.
    hs("t6_m1",   0, 4'b0001, 1, 4'b1000, 0, 0,   0, 1, 0, 4'b0000, 4'b1000);
    hs("t6_m2",   0, 4'b0001, 0, 4'b0000, 0, 0,   0, 1, 0, 4'b0000, 4'b1000);
    hs("t6_pend", 0, 4'b0000, 0, 4'b0000, 0, 0,   0, 1, 0, 4'b0001, 4'b1000);
    hs("t6_req",  0, 4'b0000, 0, 4'b0000, 0, 0,   1, 0, 0, 4'b0001, 4'b1000);
    hs("t6_rst",  1, 4'b0000, 0, 4'b0000, 0, 0,   0, 0, 0, 4'b0000, 4'b0000);
    hs("t6_ack",  0, 4'b0000, 0, 4'b0000, 1, 0,   0, 0, 0, 4'b0000, 4'b0000);
    hs("t6_hold", 0, 4'b0000, 0, 4'b0000, 0, 0,   0, 0, 0, 4'b0000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
